game_round_ctrl: RTL and testbench

Round sequencer for the binary-number game. Each round it loads a target from the free-running random source, runs a per-round countdown on the clock-enable tick, captures the player's switch value on Select, and judges it. It maintains the current score and the session high score. It sits between the menu state machine, which issues Start/Mode/Quit, and the display/LED datapath, which shows target, score and time.

---
 rtl/game_round_ctrl.sv | 166 ++++++++++++++++
 tb/tb_game_round_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/game_round_ctrl.sv
// Round sequencer for the binary-number game: target load, countdown, guess judging, scoring.
// Optional build macro SPEEDUP_ROUNDS_EN shortens the round limit after every 4th play-mode win.
module game_round_ctrl #(
   parameter int TIME_LIMIT = 10,
   parameter int MIN_TIME   = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       CEN,
   input  logic       Start,
   input  logic       Mode,
   input  logic       Select,
   input  logic       Quit,
   input  logic [7:0] userNumber,
   input  logic [7:0] rnd,
   output logic [7:0] target,
   output logic [7:0] score,
   output logic [7:0] highScore,
   output logic [3:0] timeLeft,
   output logic       roundWin,
   output logic       roundLose,
   output logic       q_Idle,
   output logic       q_Load,
   output logic       q_Wait,
   output logic       q_Check,
   output logic       q_Over
);

   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      LOAD  = 5'b00010,
      WAIT  = 5'b00100,
      CHECK = 5'b01000,
      OVER  = 5'b10000
   } state_t;

   localparam logic [3:0] LIMIT4 = 4'(TIME_LIMIT);

   if (TIME_LIMIT < 2 || TIME_LIMIT > 15 || MIN_TIME < 1 || MIN_TIME > TIME_LIMIT) begin : g_bad_params
      $error("game_round_ctrl: illegal TIME_LIMIT/MIN_TIME combination");
   end

   state_t     state;
   state_t     state_next;
   logic [7:0] guessReg;
   logic       modeReg;
   logic [3:0] curLimit;
   logic       guess_match;
   logic       score_full;

   assign guess_match = (guessReg == target);
   assign score_full  = (score == 8'hFF);

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Quit outranks Select everywhere; a timeout needs the last tick with no Select pending.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (Start) state_next = LOAD;
         LOAD:    state_next = WAIT;
         WAIT: begin
            if (Quit)                                             state_next = OVER;
            else if (Select)                                      state_next = CHECK;
            else if (CEN && !modeReg && timeLeft == 4'd1)         state_next = OVER;
         end
         CHECK: begin
            if (Quit)             state_next = OVER;
            else if (guess_match) state_next = LOAD;
            else if (modeReg)     state_next = WAIT;
            else                  state_next = OVER;
         end
         OVER:    if (Select || Quit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         target    <= 8'd0;
         score     <= 8'd0;
         highScore <= 8'd0;
         timeLeft  <= 4'd0;
         guessReg  <= 8'd0;
         modeReg   <= 1'b0;
         roundWin  <= 1'b0;
         roundLose <= 1'b0;
      end else begin
         roundWin  <= 1'b0;
         roundLose <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  modeReg <= Mode;
                  score   <= 8'd0;
               end
            end
            LOAD: begin
               target   <= rnd;
               timeLeft <= curLimit;
            end
            WAIT: begin
               if (!Quit) begin
                  if (Select) begin
                     guessReg <= userNumber;
                  end else if (CEN && !modeReg) begin
                     if (timeLeft > 4'd1) begin
                        timeLeft <= timeLeft - 4'd1;
                     end else if (timeLeft == 4'd1) begin
                        timeLeft  <= 4'd0;
                        roundLose <= 1'b1;
                     end
                  end
               end
            end
            CHECK: begin
               if (!Quit) begin
                  if (guess_match) begin
                     roundWin <= 1'b1;
                     if (!score_full) score <= score + 8'd1;
                  end else begin
                     roundLose <= 1'b1;
                     if (modeReg) timeLeft <= curLimit;
                  end
               end
            end
            OVER: begin
               // Score is frozen in OVER, so updating on every OVER cycle equals updating on entry.
               if (!modeReg && score > highScore) highScore <= score;
            end
            default: ;
         endcase
      end
   end

`ifdef SPEEDUP_ROUNDS_EN
   localparam logic [3:0] MIN4 = 4'(MIN_TIME);

   // A win that moves score[1:0] from 11 to 00 tightens the limit for the next LOAD.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         curLimit <= LIMIT4;
      end else if (state == IDLE && Start) begin
         curLimit <= LIMIT4;
      end else if (state == CHECK && !Quit && guess_match && !modeReg && !score_full &&
                   score[1:0] == 2'b11 && curLimit > MIN4) begin
         curLimit <= curLimit - 4'd1;
      end
   end
`else
   assign curLimit = LIMIT4;
`endif

   assign q_Idle  = (state == IDLE);
   assign q_Load  = (state == LOAD);
   assign q_Wait  = (state == WAIT);
   assign q_Check = (state == CHECK);
   assign q_Over  = (state == OVER);

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed-vector bench for game_round_ctrl: table of per-cycle vectors plus long-run sequences.
// Honours SPEEDUP_ROUNDS_EN when expecting round limits.
module tb_game_round_ctrl;

   localparam logic [4:0] S_I = 5'b00001;
   localparam logic [4:0] S_L = 5'b00010;
   localparam logic [4:0] S_W = 5'b00100;
   localparam logic [4:0] S_C = 5'b01000;
   localparam logic [4:0] S_O = 5'b10000;

   typedef struct {
      logic       rst_n, start, mode, sel, quit, cen;
      logic [7:0] user, rnd;
      logic [4:0] st;
      logic [7:0] tgt, sc, hs;
      logic [3:0] tl;
      logic       win, lose;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       cen, start, mode, sel, quit;
   logic [7:0] user_number, rnd;
   logic [7:0] target, score, high_score;
   logic [3:0] time_left;
   logic       round_win, round_lose;
   logic       q_idle, q_load, q_wait, q_check, q_over;

   int tests_run = 0;
   int tests_failed = 0;
   vec_t vecs[$];

   game_round_ctrl #(.TIME_LIMIT(10), .MIN_TIME(2)) dut (
      .Clk(clk), .Reset(rst_n), .CEN(cen), .Start(start), .Mode(mode),
      .Select(sel), .Quit(quit), .userNumber(user_number), .rnd(rnd),
      .target(target), .score(score), .highScore(high_score), .timeLeft(time_left),
      .roundWin(round_win), .roundLose(round_lose),
      .q_Idle(q_idle), .q_Load(q_load), .q_Wait(q_wait), .q_Check(q_check), .q_Over(q_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic addVec(input logic r, input logic st_in, input logic m, input logic s,
                         input logic q, input logic c, input logic [7:0] u, input logic [7:0] rn,
                         input logic [4:0] est, input logic [7:0] etgt, input logic [7:0] esc,
                         input logic [7:0] ehs, input logic [3:0] etl, input logic ew, input logic el);
      vec_t v;
      v.rst_n = r; v.start = st_in; v.mode = m; v.sel = s; v.quit = q; v.cen = c;
      v.user = u; v.rnd = rn; v.st = est; v.tgt = etgt; v.sc = esc; v.hs = ehs;
      v.tl = etl; v.win = ew; v.lose = el;
      vecs.push_back(v);
   endtask

   // Drives one cycle of inputs at the falling edge and returns 1 ns after the next rising edge.
   task automatic applyStimulus(input logic r, input logic st_in, input logic m, input logic s,
                                input logic q, input logic c, input logic [7:0] u, input logic [7:0] rn);
      @(negedge clk);
      rst_n = r; start = st_in; mode = m; sel = s; quit = q; cen = c;
      user_number = u; rnd = rn;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input int idx, input vec_t v);
      logic [38:0] act, expv;
      act  = {q_over, q_check, q_wait, q_load, q_idle, target, score, high_score, time_left, round_win, round_lose};
      expv = {v.st, v.tgt, v.sc, v.hs, v.tl, v.win, v.lose};
      tests_run++;
      if (act !== expv) begin
         tests_failed++;
         $display("[TB] FAIL vec%0d: got st=%b tgt=%h sc=%h hs=%h tl=%0d w=%b l=%b, want st=%b tgt=%h sc=%h hs=%h tl=%0d w=%b l=%b",
                  idx, act[38:34], target, score, high_score, time_left, round_win, round_lose,
                  v.st, v.tgt, v.sc, v.hs, v.tl, v.win, v.lose);
      end
   endtask

   task automatic checkVal(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
      end
   endtask

   function automatic int expLimit(input int wins);
      int l;
      l = 10;
`ifdef SPEEDUP_ROUNDS_EN
      l = 10 - wins / 4;
      if (l < 2) l = 2;
`endif
      return l;
   endfunction

   function automatic logic [7:0] roundRnd(input int w);
      logic [7:0] x;
      x = 8'(w * 37 + 11);
      return x;
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; sel = 1'b0; quit = 1'b0; cen = 1'b0;
      user_number = 8'h00; rnd = 8'h00;

      // Reset, first play round and a correct guess
      addVec(0,1,0,0,0,0,8'h00,8'h33, S_I,8'h00,8'd0,8'd0,4'd0,0,0);
      addVec(0,0,0,1,1,1,8'h00,8'h33, S_I,8'h00,8'd0,8'd0,4'd0,0,0);
      addVec(1,1,0,0,0,0,8'h00,8'h5A, S_L,8'h00,8'd0,8'd0,4'd0,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h5A, S_W,8'h5A,8'd0,8'd0,4'd10,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h5A, S_W,8'h5A,8'd0,8'd0,4'd10,0,0);
      addVec(1,0,0,1,0,0,8'h5A,8'h77, S_C,8'h5A,8'd0,8'd0,4'd10,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h77, S_L,8'h5A,8'd1,8'd0,4'd10,1,0);
      addVec(1,0,0,0,0,0,8'h00,8'h77, S_W,8'h77,8'd1,8'd0,4'd10,0,0);
      // Timeout in play mode
      for (int t = 9; t >= 1; t--)
         addVec(1,0,0,0,0,1,8'h00,8'h77, S_W,8'h77,8'd1,8'd0,4'(t),0,0);
      addVec(1,0,0,0,0,1,8'h00,8'h77, S_O,8'h77,8'd1,8'd0,4'd0,0,1);
      addVec(1,0,0,0,0,0,8'h00,8'h77, S_O,8'h77,8'd1,8'd1,4'd0,0,0);
      addVec(1,1,0,0,0,1,8'h00,8'h77, S_O,8'h77,8'd1,8'd1,4'd0,0,0);
      addVec(1,0,0,1,0,0,8'h00,8'h77, S_I,8'h77,8'd1,8'd1,4'd0,0,0);
      addVec(1,0,0,1,1,1,8'h00,8'h77, S_I,8'h77,8'd1,8'd1,4'd0,0,0);
      // Practice: frozen countdown, retry on miss, highScore untouched
      addVec(1,1,1,0,0,0,8'h00,8'hC3, S_L,8'h77,8'd0,8'd1,4'd0,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'hC3, S_W,8'hC3,8'd0,8'd1,4'd10,0,0);
      addVec(1,0,0,0,0,1,8'h00,8'hC3, S_W,8'hC3,8'd0,8'd1,4'd10,0,0);
      addVec(1,0,0,1,0,0,8'hC2,8'hC3, S_C,8'hC3,8'd0,8'd1,4'd10,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h99, S_W,8'hC3,8'd0,8'd1,4'd10,0,1);
      addVec(1,0,0,1,0,0,8'hC3,8'h11, S_C,8'hC3,8'd0,8'd1,4'd10,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h11, S_L,8'hC3,8'd1,8'd1,4'd10,1,0);
      addVec(1,0,0,0,0,0,8'h00,8'h11, S_W,8'h11,8'd1,8'd1,4'd10,0,0);
      addVec(1,0,0,1,0,0,8'h11,8'h22, S_C,8'h11,8'd1,8'd1,4'd10,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h22, S_L,8'h11,8'd2,8'd1,4'd10,1,0);
      addVec(1,0,0,0,0,0,8'h00,8'h22, S_W,8'h22,8'd2,8'd1,4'd10,0,0);
      addVec(1,0,0,1,1,0,8'h22,8'h22, S_O,8'h22,8'd2,8'd1,4'd10,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h22, S_O,8'h22,8'd2,8'd1,4'd10,0,0);
      addVec(1,0,0,0,1,0,8'h00,8'h22, S_I,8'h22,8'd2,8'd1,4'd10,0,0);
      // Select together with the final tick: guess wins over timeout
      addVec(1,1,0,0,0,0,8'h00,8'h40, S_L,8'h22,8'd0,8'd1,4'd10,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h40, S_W,8'h40,8'd0,8'd1,4'd10,0,0);
      for (int t = 9; t >= 1; t--)
         addVec(1,0,0,0,0,1,8'h00,8'h40, S_W,8'h40,8'd0,8'd1,4'(t),0,0);
      addVec(1,0,0,1,0,1,8'h40,8'h40, S_C,8'h40,8'd0,8'd1,4'd1,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h6E, S_L,8'h40,8'd1,8'd1,4'd1,1,0);
      addVec(1,0,0,0,0,0,8'h00,8'h6E, S_W,8'h6E,8'd1,8'd1,4'd10,0,0);
      // Quit during CHECK abandons without a pulse
      addVec(1,0,0,1,0,0,8'h00,8'h6E, S_C,8'h6E,8'd1,8'd1,4'd10,0,0);
      addVec(1,0,0,0,1,0,8'h00,8'h6E, S_O,8'h6E,8'd1,8'd1,4'd10,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h6E, S_O,8'h6E,8'd1,8'd1,4'd10,0,0);
      addVec(1,0,0,1,0,0,8'h00,8'h6E, S_I,8'h6E,8'd1,8'd1,4'd10,0,0);
      // Wrong guess in play mode ends the session
      addVec(1,1,0,0,0,0,8'h00,8'h81, S_L,8'h6E,8'd0,8'd1,4'd10,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h81, S_W,8'h81,8'd0,8'd1,4'd10,0,0);
      addVec(1,0,0,1,0,0,8'h80,8'h81, S_C,8'h81,8'd0,8'd1,4'd10,0,0);
      addVec(1,0,0,0,0,0,8'h00,8'h81, S_O,8'h81,8'd0,8'd1,4'd10,0,1);
      addVec(1,0,0,0,0,0,8'h00,8'h81, S_O,8'h81,8'd0,8'd1,4'd10,0,0);
      addVec(1,0,0,0,1,0,8'h00,8'h81, S_I,8'h81,8'd0,8'd1,4'd10,0,0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst_n, vecs[i].start, vecs[i].mode, vecs[i].sel,
                       vecs[i].quit, vecs[i].cen, vecs[i].user, vecs[i].rnd);
         checkOutput(i, vecs[i]);
      end

      // 256 consecutive wins: score saturation and per-round limit
      applyStimulus(1,1,0,0,0,0,8'h00,roundRnd(0));
      applyStimulus(1,0,0,0,0,0,8'h00,roundRnd(0));
      for (int w = 0; w < 256; w++) begin
         checkVal($sformatf("round%0d timeLeft", w), int'(time_left), expLimit(w));
         checkVal($sformatf("round%0d target", w), int'(target), int'(roundRnd(w)));
         applyStimulus(1,0,0,1,0,0,roundRnd(w),roundRnd(w));
         applyStimulus(1,0,0,0,0,0,8'h00,roundRnd(w + 1));
         checkVal($sformatf("round%0d win/lose", w), int'({round_win, round_lose}), 2);
         checkVal($sformatf("round%0d score", w), int'(score), (w + 1 > 255) ? 255 : w + 1);
         applyStimulus(1,0,0,0,0,0,8'h00,roundRnd(w + 1));
      end
      applyStimulus(1,0,0,0,1,0,8'h00,8'h00);
      checkVal("quit after run q_Over", int'(q_over), 1);
      applyStimulus(1,0,0,0,0,0,8'h00,8'h00);
      checkVal("highScore after 255", int'(high_score), 255);
      applyStimulus(1,0,0,1,0,0,8'h00,8'h00);
      checkVal("back to idle", int'(q_idle), 1);

      // Mid-round reset discards everything including highScore
      applyStimulus(1,1,0,0,0,0,8'h00,8'hE7);
      applyStimulus(1,0,0,0,0,0,8'h00,8'hE7);
      checkVal("pre-reset target", int'(target), 8'hE7);
      applyStimulus(0,0,0,1,0,1,8'hE7,8'hE7);
      checkVal("reset state idle", int'({q_over, q_check, q_wait, q_load, q_idle}), int'(S_I));
      checkVal("reset highScore", int'(high_score), 0);
      checkVal("reset outputs", int'({target, score, time_left, round_win, round_lose}), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
